cordic_prerotate: RTL and testbench
===================================

CORDIC_PREROTATE -- requirements
Module: cordic_prerotate

Interface
REQ-001 Parameter TWO_PI, default 6434: 2*pi in Q10 angle units (1024 = 1.0 rad); PI = TWO_PI>>1 (3217), HALF_PI = TWO_PI>>2 (1608), THREE_HALF_PI = PI+HALF_PI (4825).
REQ-002 Parameter X_INIT, default 622: 1/K CORDIC gain compensation in Q10.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_angle  input  32  signed angle, Q10 radians, full 32-bit range.
REQ-006 in_valid  input  1  in_angle is valid this cycle.
REQ-007 in_ready  output  1  block can accept an angle; high only in IDLE, combinational from state.
REQ-008 x0  output  32  signed initial x for the 16-stage CORDIC pipeline, registered.
REQ-009 y0  output  32  initial y, registered, always 0.
REQ-010 z0  output  32  signed residual angle in [-HALF_PI-1, HALF_PI], registered.
REQ-011 out_valid  output  1  one-cycle pulse marking x0/y0/z0 as a new result.

Function
REQ-012 FSM states IDLE, REDUCE, FOLD, DONE; IDLE->REDUCE on accept, REDUCE->FOLD after 19 steps, FOLD->DONE, DONE->IDLE, one edge each for FOLD and DONE.
REQ-013 Accept = in_valid && in_ready at a rising edge; capture sign of in_angle and unsigned 32-bit magnitude (-2^31 -> 2^31), load step index k=18.
REQ-014 in_valid while not in IDLE is ignored; no angle is buffered or dropped silently beyond that.
REQ-015 REDUCE: each edge, if rem >= (TWO_PI<<k) then rem -= (TWO_PI<<k); k decrements; 19 edges (k=18..0) leave rem = |in_angle| mod TWO_PI.
REQ-016 FOLD edge: r = rem if sign positive or rem==0, else r = TWO_PI - rem.
REQ-017 Fold regions: r <= HALF_PI -> z0=r, x0=+X_INIT; HALF_PI < r <= THREE_HALF_PI -> z0=r-PI, x0=-X_INIT; r > THREE_HALF_PI -> z0=r-TWO_PI, x0=+X_INIT; y0=0 always.
REQ-018 x0, y0, z0 and out_valid update on the FOLD edge; out_valid cleared on the following (DONE) edge; x0/y0/z0 hold until the next FOLD edge.
REQ-019 Latency: out_valid is high after the 20th rising edge following the accept edge; initiation interval 22 cycles.
REQ-020 All arithmetic 32-bit; z0 sign-extended two's complement; no overflow is possible for any input.

Reset
REQ-021 rst high forces, asynchronously: state IDLE, x0=0, y0=0, z0=0, out_valid=0, k=18, rem=0, sign=0; in_ready=1 once released.
REQ-022 rst asserted mid-REDUCE or in FOLD discards the operation; no out_valid pulse results from it.

Configuration
REQ-023 Macro CORDIC_PREROTATE_QUAD_EN defined: extra output quad [1:0], registered on the FOLD edge, reset 0; 0 for r<=HALF_PI, 1 for HALF_PI<r<PI, 2 for PI<=r<=THREE_HALF_PI, 3 for r>THREE_HALF_PI.
REQ-024 Macro undefined: port quad absent; all other behaviour identical.

Verification
REQ-025 in_angle=804 accepted -> after 20 edges out_valid=1 for one cycle, x0=622, y0=0, z0=804 (quad=0).
REQ-026 in_angle=3317 -> x0=-622, z0=100 (quad=2); in_angle=4825 -> x0=-622, z0=1608.
REQ-027 in_angle=-804 -> x0=622, z0=-804 (quad=3); in_angle=32180 (5*TWO_PI+10) -> x0=622, z0=10.
REQ-028 in_angle=-2147483648 -> rem=1034, r=5400, x0=622, z0=-1034; in_angle=-6434 -> r=0, z0=0, x0=622.
REQ-029 Back-to-back: in_valid held high continuously -> in_ready low from the accept edge until DONE returns to IDLE, exactly one accept per 22 cycles, no extra out_valid pulses.
REQ-030 rst pulsed 10 cycles after accept -> out_valid stays 0, outputs 0, in_ready 1 after release; next angle 1608 returns z0=1608, x0=622 with normal latency.

Source files
------------

// File: rtl/cordic_prerotate.sv
// cordic_prerotate: reduces a signed Q10 angle into [-HALF_PI-1, HALF_PI] and
// seeds the 16-stage CORDIC pipeline with (x0, y0, z0).
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_angle   signed Q10 angle (1024 = 1.0 rad), full 32-bit range
//   in_valid   in_angle valid this cycle
//   in_ready   block idle and able to accept (combinational from state)
//   x0,y0,z0   registered CORDIC seed; y0 is always 0
//   out_valid  one-cycle pulse marking a new x0/y0/z0
//   quad       (only with CORDIC_PREROTATE_QUAD_EN) quadrant of the folded angle
//
// Optional feature macro: CORDIC_PREROTATE_QUAD_EN adds the quad output.
module cordic_prerotate #(
  parameter int unsigned TWO_PI = 6434,
  parameter int unsigned X_INIT = 622
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] in_angle,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] x0,
  output logic signed [31:0] y0,
  output logic signed [31:0] z0,
`ifdef CORDIC_PREROTATE_QUAD_EN
  output logic [1:0]         quad,
`endif
  output logic               out_valid
);

  localparam int unsigned W = 32;
  localparam int unsigned KW = 5;

  localparam logic [W-1:0] LP_TWO_PI        = W'(TWO_PI);
  localparam logic [W-1:0] LP_PI            = LP_TWO_PI >> 1;
  localparam logic [W-1:0] LP_HALF_PI       = LP_TWO_PI >> 2;
  localparam logic [W-1:0] LP_THREE_HALF_PI = LP_PI + LP_HALF_PI;
  localparam logic signed [W-1:0] LP_X_POS  = W'(X_INIT);
  localparam logic signed [W-1:0] LP_X_NEG  = -LP_X_POS;
  localparam logic [KW-1:0] LP_K_START      = KW'(18);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_FOLD   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_rem;
  logic          r_sign;

  logic          w_accept;
  logic [W-1:0]  w_angle_u;
  logic [W-1:0]  w_mag;
  logic [W-1:0]  w_step;
  logic [W-1:0]  w_r;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_angle_u = in_angle;
  // -2^31 maps to 2^31, which is representable as an unsigned 32-bit value
  assign w_mag     = in_angle[W-1] ? (~w_angle_u + W'(1)) : w_angle_u;
  // TWO_PI<<18 still fits below 2^31, so the shift never overflows
  assign w_step    = LP_TWO_PI << r_k;
  // Negative angles map to TWO_PI - (|a| mod TWO_PI), except an exact multiple
  assign w_r       = (r_sign && (r_rem != '0)) ? (LP_TWO_PI - r_rem) : r_rem;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (in_valid)  w_next_state = S_REDUCE;
      S_REDUCE: if (r_k == '0) w_next_state = S_FOLD;
      S_FOLD:   w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Restoring reduction datapath and registered CORDIC seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k       <= LP_K_START;
      r_rem     <= '0;
      r_sign    <= 1'b0;
      x0        <= '0;
      y0        <= '0;
      z0        <= '0;
      out_valid <= 1'b0;
`ifdef CORDIC_PREROTATE_QUAD_EN
      quad      <= 2'd0;
`endif
    end else begin
      out_valid <= (r_state == S_FOLD);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign <= in_angle[W-1];
            r_rem  <= w_mag;
            r_k    <= LP_K_START;
          end
        end
        S_REDUCE: begin
          if (r_rem >= w_step) r_rem <= r_rem - w_step;
          if (r_k != '0)       r_k   <= r_k - KW'(1);
        end
        S_FOLD: begin
          y0 <= '0;
          if (w_r <= LP_HALF_PI) begin
            z0 <= w_r;
            x0 <= LP_X_POS;
          end else if (w_r <= LP_THREE_HALF_PI) begin
            z0 <= w_r - LP_PI;
            x0 <= LP_X_NEG;
          end else begin
            z0 <= w_r - LP_TWO_PI;
            x0 <= LP_X_POS;
          end
`ifdef CORDIC_PREROTATE_QUAD_EN
          if (w_r <= LP_HALF_PI)            quad <= 2'd0;
          else if (w_r < LP_PI)             quad <= 2'd1;
          else if (w_r <= LP_THREE_HALF_PI) quad <= 2'd2;
          else                              quad <= 2'd3;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_prerotate.sv
// tb_cordic_prerotate: randomized and directed bench for cordic_prerotate with
// an arithmetic reference model and an expectation queue.
module tb_cordic_prerotate;

  localparam longint TP    = 6434;
  localparam longint PI_V  = 3217;
  localparam longint HP    = 1608;
  localparam longint THP   = 4825;
  localparam longint XI    = 622;

  logic               clk;
  logic               rst;
  logic signed [31:0] in_angle;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] x0, y0, z0;
  logic               out_valid;
`ifdef CORDIC_PREROTATE_QUAD_EN
  logic [1:0]         quad;
`endif

  cordic_prerotate dut (
    .clk(clk), .rst(rst), .in_angle(in_angle), .in_valid(in_valid),
    .in_ready(in_ready), .x0(x0), .y0(y0), .z0(z0),
`ifdef CORDIC_PREROTATE_QUAD_EN
    .quad(quad),
`endif
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint x;
    longint z;
    longint q;
    longint acc;
  } exp_t;

  exp_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_acc = 0;
  bit     have_prev = 0;
  bit     b2b = 0;
  bit     prev_ov = 0;
  int     n_acc = 0;
  int     n_res = 0;
  int     n_b2b = 0;

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: true modulo into [0, TWO_PI), then region fold
  function automatic exp_t model(input logic signed [31:0] a);
    exp_t e;
    longint r;
    r = longint'(a) % TP;
    if (r < 0) r = r + TP;
    if (r <= HP)       begin e.z = r;        e.x = XI;  end
    else if (r <= THP) begin e.z = r - PI_V; e.x = -XI; end
    else               begin e.z = r - TP;   e.x = XI;  end
    if (r <= HP)        e.q = 0;
    else if (r < PI_V)  e.q = 1;
    else if (r <= THP)  e.q = 2;
    else                e.q = 3;
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: records accepts, matches every out_valid pulse to one
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e = model(in_angle);
        e.acc = cyc + 1;
        if (b2b && have_prev) check("b2b_gap", e.acc - last_acc, 22);
        if (b2b) n_b2b++;
        last_acc = e.acc;
        have_prev = 1'b1;
        n_acc++;
        exp_q.push_back(e);
      end
      if (out_valid) begin
        check("ov_single_cycle", longint'(prev_ov), 0);
        if (exp_q.size() == 0) begin
          check("ov_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          n_res++;
          check("latency", cyc - e.acc, 20);
          check("x0", longint'(x0), e.x);
          check("y0", longint'(y0), 0);
          check("z0", longint'(z0), e.z);
`ifdef CORDIC_PREROTATE_QUAD_EN
          check("quad", longint'(quad), e.q);
`endif
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic signed [31:0] a);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("ready_wait", longint'(in_ready), 1);
    in_angle = a;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ready_low_after_accept", longint'(in_ready), 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("drain", longint'(exp_q.size()), 0);
  endtask

  logic signed [31:0] d_ang [7] = '{32'sd804, 32'sd3317, 32'sd4825, -32'sd804,
                                    32'sd32180, 32'h80000000, -32'sd6434};
  longint d_x [7] = '{622, -622, -622, 622, 622, 622, 622};
  longint d_z [7] = '{804, 100, 1608, -804, 10, -1034, 0};
`ifdef CORDIC_PREROTATE_QUAD_EN
  longint d_q [7] = '{0, 2, 2, 3, 0, 3, 0};
`endif

  initial begin
    logic signed [31:0] a;
    int sel;
    int res_before;
    rst = 1'b1;
    in_valid = 1'b0;
    in_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x0", longint'(x0), 0);
    check("rst_y0", longint'(y0), 0);
    check("rst_z0", longint'(z0), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", longint'(in_ready), 1);

    // Directed corner angles with literal expectations
    for (int i = 0; i < 7; i++) begin
      send(d_ang[i]);
      drain();
      check("dir_x0", longint'(x0), d_x[i]);
      check("dir_z0", longint'(z0), d_z[i]);
`ifdef CORDIC_PREROTATE_QUAD_EN
      check("dir_quad", longint'(quad), d_q[i]);
`endif
    end

    // Random angles, including extremes and near-multiples of TWO_PI
    for (int i = 0; i < 25; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: a = 32'h80000000;
        1: a = 32'h7fffffff;
        2: a = 32'(longint'($urandom_range(0, 300000)) * TP - 1 + longint'($urandom_range(0, 2)));
        3: a = -32'(longint'($urandom_range(0, 300000)) * TP + longint'($urandom_range(0, 2)));
        4: a = 32'(longint'($urandom_range(0, 6)) * HP + longint'($urandom_range(0, 2)) - 1);
        default: a = $urandom;
      endcase
      send(a);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    // Back-to-back: in_valid held high with a new angle every cycle
    have_prev = 1'b0;
    b2b = 1'b1;
    in_valid = 1'b1;
    repeat (100) begin
      in_angle = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    drain();
    check("b2b_accepts", longint'(n_b2b), 5);

    // Reset mid-reduction discards the operation
    send(32'sd1000);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    res_before = n_res;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_x0", longint'(x0), 0);
    check("midrst_z0", longint'(z0), 0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", longint'(in_ready), 1);
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_result", longint'(n_res), longint'(res_before));
    send(32'sd1608);
    drain();
    check("post_rst_x0", longint'(x0), 622);
    check("post_rst_z0", longint'(z0), 1608);

    repeat (3) @(posedge clk);
    #1;
    check("results_vs_accepts", longint'(n_res), longint'(n_acc - 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
